// File: rtl/memory_stage.sv
// memory_stage -- MEM pipeline stage plus the MEM/WB pipeline register.
//
// Runs loads and stores from the EX/MEM register on a req/ack data-memory bus.
// While an access is outstanding it stalls the upstream pipeline and injects
// bubbles into MEM/WB, so each instruction writes back exactly once.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles. The abort pulses me_BusErr and writes back zero load
// data. Without the macro, WAIT is unbounded and me_BusErr is tied low.
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   ex_*                EX/MEM register outputs (held stable while me_Stall=1)
//   dm_Req/We/Addr/WrData  data-memory request (combinational)
//   dm_Ack, dm_RdData   memory completion and load data (same cycle)
//   me_Stall            freezes PC, IF/ID, ID/EX and EX/MEM
//   me_Data, me_RegDest, me_RegWriteSel, me_MemRegSel  MEM/WB register
//   wr_Data             write-back value and forwarding source
//   me_BusErr           one-cycle pulse on timeout abort
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_MemWr,
  input  logic        ex_MemRd,
  input  logic [31:0] ex_ALUOut,
  input  logic [31:0] ex_OpB_pre,
  input  logic [4:0]  ex_RegDest,
  input  logic        ex_MemRegSel,
  input  logic        ex_RegWriteSel,
  output logic        dm_Req,
  output logic        dm_We,
  output logic [31:0] dm_Addr,
  output logic [31:0] dm_WrData,
  input  logic        dm_Ack,
  input  logic [31:0] dm_RdData,
  output logic        me_Stall,
  output logic [31:0] me_Data,
  output logic [4:0]  me_RegDest,
  output logic        me_RegWriteSel,
  output logic        me_MemRegSel,
  output logic [31:0] wr_Data,
  output logic        me_BusErr
);

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if ((1 << TO_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
    $error("memory_stage: TO_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic        mem_op;
  logic        req_c;
  logic        stall_c;
  logic        abort_c;
  logic        timeout_hit;
  logic [31:0] me_LoadData;

  assign mem_op    = ex_MemRd | ex_MemWr;
  // A simultaneous read+write is issued as a write.
  assign dm_We     = ex_MemWr;
  assign dm_Addr   = ex_ALUOut;
  assign dm_WrData = ex_OpB_pre;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Cleared every IDLE cycle, so it starts at zero on entry to WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      me_BusErr <= 1'b0;
    end else begin
      me_BusErr <= abort_c;
      if (state == S_IDLE)
        to_cnt <= '0;
      else if (!dm_Ack && !timeout_hit)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign me_BusErr   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    abort_c   = 1'b0;
    case (state)
      S_IDLE: begin
        req_c = mem_op;
        // dm_Ack without mem_op is a stray ack and is ignored.
        if (mem_op && !dm_Ack) begin
          stall_c   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        req_c = mem_op;
        if (dm_Ack) begin
          // Ack wins over a coincident timeout.
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          req_c     = 1'b0;
          abort_c   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gated by reset so the bus and the pipeline are released as soon as reset
  // asserts, even while EX/MEM still presents the interrupted access.
  assign dm_Req   = req_c & ~reset;
  assign me_Stall = stall_c & ~reset;

  // MEM/WB register: capture on every non-stalled cycle; bubble otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      me_Data        <= '0;
      me_LoadData    <= '0;
      me_RegDest     <= '0;
      me_RegWriteSel <= 1'b0;
      me_MemRegSel   <= 1'b0;
    end else if (stall_c) begin
      me_RegWriteSel <= 1'b0;
      me_MemRegSel   <= 1'b0;
    end else begin
      me_Data        <= ex_ALUOut;
      me_RegDest     <= ex_RegDest;
      me_RegWriteSel <= ex_RegWriteSel;
      me_MemRegSel   <= ex_MemRegSel;
      if (abort_c)
        me_LoadData <= '0;
      else if (ex_MemRd)
        me_LoadData <= dm_RdData;
    end
  end

  // Selected from registers only: no combinational path from dm_* to here.
  assign wr_Data = me_MemRegSel ? me_LoadData : me_Data;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_MemWr, ex_MemRd;
  logic [31:0] ex_ALUOut, ex_OpB_pre;
  logic [4:0]  ex_RegDest;
  logic        ex_MemRegSel, ex_RegWriteSel;
  logic        dm_Req, dm_We;
  logic [31:0] dm_Addr, dm_WrData;
  logic        dm_Ack;
  logic [31:0] dm_RdData;
  logic        me_Stall;
  logic [31:0] me_Data;
  logic [4:0]  me_RegDest;
  logic        me_RegWriteSel, me_MemRegSel;
  logic [31:0] wr_Data;
  logic        me_BusErr;

  memory_stage #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clock(clock), .reset(reset),
    .ex_MemWr(ex_MemWr), .ex_MemRd(ex_MemRd),
    .ex_ALUOut(ex_ALUOut), .ex_OpB_pre(ex_OpB_pre),
    .ex_RegDest(ex_RegDest), .ex_MemRegSel(ex_MemRegSel),
    .ex_RegWriteSel(ex_RegWriteSel),
    .dm_Req(dm_Req), .dm_We(dm_We), .dm_Addr(dm_Addr), .dm_WrData(dm_WrData),
    .dm_Ack(dm_Ack), .dm_RdData(dm_RdData),
    .me_Stall(me_Stall), .me_Data(me_Data), .me_RegDest(me_RegDest),
    .me_RegWriteSel(me_RegWriteSel), .me_MemRegSel(me_MemRegSel),
    .wr_Data(wr_Data), .me_BusErr(me_BusErr)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write-back the DUT presents must match the
  // oldest expected entry.
  always @(negedge clock) begin
    wb_t e;
    if (!reset && me_RegWriteSel === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_wb: got rd=%0d data=0x%08h expected no write-back",
                 me_RegDest, wr_Data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", wr_Data, e.val);
        chk("wb_dest", {27'd0, me_RegDest}, {27'd0, e.rd});
      end
    end
  end

  task automatic drive_idle();
    @(posedge clock); #1;
    ex_MemRd = 0; ex_MemWr = 0; ex_ALUOut = 0; ex_OpB_pre = 0;
    ex_RegDest = 0; ex_RegWriteSel = 0; ex_MemRegSel = 0;
    dm_Ack = 0; dm_RdData = 0;
  endtask

  // Presents one instruction; dm_Ack arrives 'delay' cycles after the first
  // request cycle. Leaves the instruction on ex_* after the completing cycle.
  task automatic issue(input logic rd_op, input logic wr_op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] dest, input logic wsel, input logic msel,
                       input int delay, input logic [31:0] rdata);
    @(posedge clock); #1;
    ex_MemRd = rd_op; ex_MemWr = wr_op; ex_ALUOut = addr; ex_OpB_pre = wdata;
    ex_RegDest = dest; ex_RegWriteSel = wsel; ex_MemRegSel = msel;
    dm_Ack = (delay == 0);
    dm_RdData = (delay == 0) ? rdata : 32'hDEAD_BEEF;
    if (wsel) exp_q.push_back('{dest, (msel ? rdata : addr)});
    #3;
    chk("req",    {31'd0, dm_Req},   {31'd0, rd_op | wr_op});
    chk("we",     {31'd0, dm_We},    {31'd0, wr_op});
    chk("addr",   dm_Addr, addr);
    chk("wrdata", dm_WrData, wdata);
    chk("stall",  {31'd0, me_Stall}, {31'd0, ((rd_op | wr_op) && delay > 0)});
    for (int i = 1; i <= delay; i++) begin
      @(posedge clock); #1;
      dm_Ack = (i == delay);
      dm_RdData = (i == delay) ? rdata : 32'hDEAD_BEEF;
      #3;
      chk("wait_stall",  {31'd0, me_Stall}, {31'd0, (i < delay)});
      chk("wait_req",    {31'd0, dm_Req}, 32'd1);
      chk("wait_we",     {31'd0, dm_We}, {31'd0, wr_op});
      chk("wait_addr",   dm_Addr, addr);
      chk("wait_wrdata", dm_WrData, wdata);
      chk("bubble_rws",  {31'd0, me_RegWriteSel}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1;
    ex_MemRd = 0; ex_MemWr = 0; ex_ALUOut = 0; ex_OpB_pre = 0;
    ex_RegDest = 0; ex_RegWriteSel = 0; ex_MemRegSel = 0;
    dm_Ack = 0; dm_RdData = 0;
    #12;
    chk("rst_stall", {31'd0, me_Stall}, 32'd0);
    chk("rst_req",   {31'd0, dm_Req}, 32'd0);
    chk("rst_data",  me_Data, 32'd0);
    chk("rst_dest",  {27'd0, me_RegDest}, 32'd0);
    chk("rst_rws",   {31'd0, me_RegWriteSel}, 32'd0);
    chk("rst_wrdat", wr_Data, 32'd0);
    chk("rst_buserr", {31'd0, me_BusErr}, 32'd0);
    @(posedge clock); #1 reset = 0;

    // ALU op; dm_Ack raised with no request must be ignored.
    issue(0, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 32'h0);
    drive_idle();
    // Zero-wait load.
    issue(1, 0, 32'h0000_0040, 32'h0, 5'd7, 1, 1, 0, 32'hCAFE_F00D);
    drive_idle();
    // Store acked after 3 cycles, no write-back.
    issue(0, 1, 32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 0, 0, 3, 32'h0);
    drive_idle();
    // Back-to-back loads, each acked after one cycle.
    issue(1, 0, 32'h0000_0010, 32'h0, 5'd8, 1, 1, 1, 32'h1111_0010);
    issue(1, 0, 32'h0000_0014, 32'h0, 5'd9, 1, 1, 1, 32'h2222_0014);
    // ALU result right after a load must not pick up load data.
    issue(0, 0, 32'h0000_0777, 32'h0, 5'd11, 1, 0, 0, 32'h0);
    drive_idle();
    drive_idle();
    chk("wb_queue_empty", exp_q.size(), 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      @(posedge clock); #1;
      ex_MemRd = 1; ex_ALUOut = 32'h60; ex_RegDest = 5'd10;
      ex_RegWriteSel = 1; ex_MemRegSel = 1; dm_Ack = 0; dm_RdData = 32'hDEAD_BEEF;
      exp_q.push_back('{5'd10, 32'h0});
      #3;
      n = 0;
      while (me_Stall === 1'b1 && n < 100) begin
        n++;
        @(posedge clock); #3;
      end
      chk("to_stall_cycles", n, 32'd17);
      chk("to_req_drop", {31'd0, dm_Req}, 32'd0);
      drive_idle();
      #3;
      chk("to_buserr", {31'd0, me_BusErr}, 32'd1);
      drive_idle();
      #3;
      chk("to_buserr_end", {31'd0, me_BusErr}, 32'd0);
    end
`endif

    // Reset in the middle of a WAIT, after an ALU op left state in MEM/WB.
    issue(0, 0, 32'h0000_0055, 32'h0, 5'd4, 1, 0, 0, 32'h0);
    @(posedge clock); #1;
    ex_MemRd = 1; ex_ALUOut = 32'h20; ex_RegDest = 5'd3;
    ex_RegWriteSel = 1; ex_MemRegSel = 1; dm_Ack = 0;
    @(posedge clock); #3;
    chk("pre_rst_stall", {31'd0, me_Stall}, 32'd1);
    chk("pre_rst_data",  me_Data, 32'h55);
    reset = 1;
    #1;
    chk("midrst_stall", {31'd0, me_Stall}, 32'd0);
    chk("midrst_req",   {31'd0, dm_Req}, 32'd0);
    chk("midrst_data",  me_Data, 32'd0);
    chk("midrst_dest",  {27'd0, me_RegDest}, 32'd0);
    chk("midrst_rws",   {31'd0, me_RegWriteSel}, 32'd0);
    chk("midrst_mrs",   {31'd0, me_MemRegSel}, 32'd0);
    chk("midrst_wrdat", wr_Data, 32'd0);
    ex_MemRd = 0; ex_ALUOut = 0; ex_RegDest = 0; ex_RegWriteSel = 0; ex_MemRegSel = 0;
    @(posedge clock); #1 reset = 0;
    @(posedge clock); #3;
    chk("post_rst_stall", {31'd0, me_Stall}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
